cpu86_exec_trace_cmp: RTL and testbench

CPU86_EXEC_TRACE_CMP -- requirements
Module: cpu86_exec_trace_cmp

---
 rtl/cpu86_exec_trace_cmp.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu86_exec_trace_cmp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu86_exec_trace_cmp.sv
// cpu86_exec_trace_cmp -- lock-step trace comparator for an x86 core.
//
// Retired-instruction records from the core under test are buffered in a
// small FIFO. Each record is compared against a golden-model record offered
// over a valid/ready handshake. Field mismatches are reported as a one-cycle
// pulse with a per-field bitmap and counted. Control transfers reported by the
// golden model trigger a resynchronisation phase that discards core records
// until one lands on the branch target. Too many mismatches halt comparison.
//
// Optional feature macro: CPU86_TRACE_CMP_STATS_EN
//   defined   -> cmp_cnt / drop_cnt statistics counters are built
//   undefined -> cmp_cnt / drop_cnt are tied to zero
//
// Record packing (both dut_regs and ref_regs), field i at [i*REG_W +: REG_W]:
//   0 CS, 1 IP, 2 AX, 3 BX, 4 CX, 5 DX, 6 BP, 7 SP, 8 SI, 9 DI, 10 FL

module cpu86_exec_trace_cmp #(
  parameter int REG_W   = 16,
  parameter int DEPTH   = 8,
  parameter int ERR_MAX = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 dut_valid,
  input  logic [11*REG_W-1:0]  dut_regs,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [11*REG_W-1:0]  ref_regs,
  input  logic [10:0]          ref_mask,
  input  logic                 ref_jumped,
  input  logic [REG_W-1:0]     ref_new_cs,
  input  logic [REG_W-1:0]     ref_new_ip,
  output logic                 mis_valid,
  output logic [10:0]          mis_fields,
  output logic [15:0]          err_cnt,
  output logic                 halted,
  output logic                 overflow,
  output logic [31:0]          cmp_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int NF    = 11;
  localparam int REC_W = NF * REG_W;
  localparam int AW    = $clog2(DEPTH);

  // CS and IP are always compared: a wrong instruction address means the
  // two traces are no longer describing the same instruction.
  localparam logic [10:0] FORCED_MASK = 11'h003;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CMP    = 2'd0,
    ST_RESYNC = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t state, state_next;

  // FIFO storage and pointers; pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate occupancy count.
  logic [REC_W-1:0]    mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full;
  logic [REC_W-1:0]    head;
  logic                push, push_drop, pop;

  // Comparison datapath
  logic                xfer;
  logic [10:0]         eff_mask;
  logic [10:0]         diff;
  logic                any_mis;
  logic [15:0]         err_inc;
  logic                err_hit;

  // Resync target and head instruction address
  logic [2*REG_W-1:0]  target;
  logic [2*REG_W-1:0]  head_cs_ip;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_cs_ip = {head[0*REG_W +: REG_W], head[1*REG_W +: REG_W]};

  // A push is accepted when there is room, or when the head leaves in the
  // same cycle. A record offered together with clr is discarded.
  assign push      = dut_valid && !clr && (!fifo_full || pop);
  assign push_drop = dut_valid && !clr && fifo_full && !pop;

  assign halted    = (state == ST_HALT);

  // Field-by-field compare of the FIFO head against the golden record.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before any
    // conditional code; a path that leaves one unassigned would infer a latch.
    diff     = '0;
    eff_mask = ref_mask | FORCED_MASK;
    for (int i = 0; i < NF; i++) begin
      diff[i] = eff_mask[i] &&
                (head[i*REG_W +: REG_W] != ref_regs[i*REG_W +: REG_W]);
    end
    any_mis = |diff;
    err_inc = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
    err_hit = any_mis && (int'(err_inc) == ERR_MAX);
  end

  // Next-state, handshake and pop decode.
  always_comb begin
    state_next = state;
    ref_ready  = 1'b0;
    xfer       = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_CMP: begin
        ref_ready = !fifo_empty;
        xfer      = ref_valid && !fifo_empty;
        pop       = xfer;
        if (xfer) begin
          // Halting wins over a pending resync.
          if (err_hit) begin
            state_next = ST_HALT;
          end else if (ref_jumped) begin
            state_next = ST_RESYNC;
          end
        end
      end
      ST_RESYNC: begin
        // Drop one stale record per cycle until the head sits on the target;
        // the matching record stays in the FIFO for normal comparison.
        if (!fifo_empty) begin
          if (head_cs_ip == target) begin
            state_next = ST_CMP;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_CMP;
      end
    endcase
    if (clr) begin
      state_next = ST_CMP;
    end
  end

  // FIFO data array write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; its contents are never observed
    // unless the pointers say an entry is valid, and the pointers are reset.
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= dut_regs;
    end
  end

  // State register, FIFO pointers, overflow flag and resync target.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this clock edge.
    if (reset) begin
      state    <= ST_CMP;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      target   <= '0;
    end else if (clr) begin
      state    <= ST_CMP;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      target   <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (xfer && ref_jumped) begin
        target <= {ref_new_cs, ref_new_ip};
      end
    end
  end

  // Registered mismatch report and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_valid  <= 1'b0;
      mis_fields <= '0;
      err_cnt    <= '0;
    end else if (clr) begin
      mis_valid  <= 1'b0;
      mis_fields <= '0;
      err_cnt    <= '0;
    end else begin
      mis_valid  <= xfer && any_mis;
      mis_fields <= xfer ? diff : '0;
      if (xfer && any_mis) begin
        err_cnt <= err_inc;
      end
    end
  end

`ifdef CPU86_TRACE_CMP_STATS_EN
  // Statistics: compared records (wrapping) and resync drops (saturating).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      cmp_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (xfer) begin
        cmp_cnt <= cmp_cnt + 32'd1;
      end
      if (pop && (state == ST_RESYNC) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`else
  assign cmp_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu86_exec_trace_cmp.sv
// Directed testbench for cpu86_exec_trace_cmp (REG_W=16, DEPTH=8, ERR_MAX=2).
// Expected values are hand-derived per scenario; statistics expectations
// follow whether CPU86_TRACE_CMP_STATS_EN is defined for the build.

module tb_cpu86_exec_trace_cmp;

`ifdef CPU86_TRACE_CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int REG_W = 16;
  localparam int REC_W = 11 * REG_W;

  logic             clk;
  logic             reset;
  logic             clr;
  logic             dut_valid;
  logic [REC_W-1:0] dut_regs;
  logic             ref_valid;
  logic             ref_ready;
  logic [REC_W-1:0] ref_regs;
  logic [10:0]      ref_mask;
  logic             ref_jumped;
  logic [15:0]      ref_new_cs;
  logic [15:0]      ref_new_ip;
  logic             mis_valid;
  logic [10:0]      mis_fields;
  logic [15:0]      err_cnt;
  logic             halted;
  logic             overflow;
  logic [31:0]      cmp_cnt;
  logic [15:0]      drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cpu86_exec_trace_cmp #(
    .REG_W   (16),
    .DEPTH   (8),
    .ERR_MAX (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .dut_valid  (dut_valid),
    .dut_regs   (dut_regs),
    .ref_valid  (ref_valid),
    .ref_ready  (ref_ready),
    .ref_regs   (ref_regs),
    .ref_mask   (ref_mask),
    .ref_jumped (ref_jumped),
    .ref_new_cs (ref_new_cs),
    .ref_new_ip (ref_new_ip),
    .mis_valid  (mis_valid),
    .mis_fields (mis_fields),
    .err_cnt    (err_cnt),
    .halted     (halted),
    .overflow   (overflow),
    .cmp_cnt    (cmp_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Register record whose non-CS/IP/AX fields are derived from CS and IP.
  function automatic logic [REC_W-1:0] mk_rec(input logic [15:0] cs, input logic [15:0] ip,
                                              input logic [15:0] ax);
    logic [REC_W-1:0] r;
    r = '0;
    r[0*16 +: 16]  = cs;
    r[1*16 +: 16]  = ip;
    r[2*16 +: 16]  = ax;
    r[3*16 +: 16]  = ip + 16'h0100;
    r[4*16 +: 16]  = 16'hC0C0;
    r[5*16 +: 16]  = cs ^ ip;
    r[6*16 +: 16]  = 16'h0BB0;
    r[7*16 +: 16]  = 16'hFFFE;
    r[8*16 +: 16]  = {ip[14:0], 1'b0};
    r[9*16 +: 16]  = 16'h0D10;
    r[10*16 +: 16] = 16'h0202;
    return r;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [REC_W-1:0] rec);
    dut_valid = 1'b1;
    dut_regs  = rec;
    step();
    dut_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [REC_W-1:0] rec, input logic [10:0] mask,
                      input logic jmp, input logic [15:0] ncs, input logic [15:0] nip);
    check({tag, "_rdy"}, 32'(ref_ready), 32'd1);
    ref_valid  = 1'b1;
    ref_regs   = rec;
    ref_mask   = mask;
    ref_jumped = jmp;
    ref_new_cs = ncs;
    ref_new_ip = nip;
    step();
    ref_valid  = 1'b0;
    ref_jumped = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Pop matching records with CS=3000, IP=first.. and count them.
  task automatic drain(input string tag, input int first, input int n);
    int got;
    int bad;
    got = 0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (!ref_ready) break;
      ref_valid = 1'b1;
      ref_regs  = mk_rec(16'h3000, 16'(first + got), 16'h7000);
      ref_mask  = 11'h7FF;
      step();
      ref_valid = 1'b0;
      if (mis_valid) bad++;
      got++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    clr        = 1'b0;
    dut_valid  = 1'b0;
    dut_regs   = '0;
    ref_valid  = 1'b0;
    ref_regs   = '0;
    ref_mask   = '0;
    ref_jumped = 1'b0;
    ref_new_cs = '0;
    ref_new_ip = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_ready",  32'(ref_ready), 32'd0);
    check("rst_mis",    32'(mis_valid), 32'd0);
    check("rst_fields", 32'(mis_fields), 32'd0);
    check("rst_err",    32'(err_cnt), 32'd0);
    check("rst_halt",   32'(halted), 32'd0);
    check("rst_ovf",    32'(overflow), 32'd0);
    check("rst_cmp",    cmp_cnt, 32'd0);
    check("rst_drop",   32'(drop_cnt), 32'd0);
    reset = 1'b0;
    step();

    // A: three matching records, full mask
    for (int i = 0; i < 3; i++) push(mk_rec(16'h1000, 16'(16 + 2 * i), 16'(16'hA000 + i)));
    for (int i = 0; i < 3; i++) begin
      send("a", mk_rec(16'h1000, 16'(16 + 2 * i), 16'(16'hA000 + i)), 11'h7FF, 1'b0, 16'h0, 16'h0);
      check("a_mis", 32'(mis_valid), 32'd0);
    end
    check("a_err",   32'(err_cnt), 32'd0);
    check("a_cmp",   cmp_cnt, STATS ? 32'd3 : 32'd0);
    check("a_empty", 32'(ref_ready), 32'd0);

    // B: AX mismatch with AX enabled, then masked off, then IP mismatch
    pulse_clr();
    push(mk_rec(16'h1000, 16'h0020, 16'h1235));
    send("b1", mk_rec(16'h1000, 16'h0020, 16'h1234), 11'h004, 1'b0, 16'h0, 16'h0);
    check("b1_mis",    32'(mis_valid), 32'd1);
    check("b1_fields", 32'(mis_fields), 32'h004);
    check("b1_err",    32'(err_cnt), 32'd1);
    step();
    check("b1_pulse",  32'(mis_valid), 32'd0);
    push(mk_rec(16'h1000, 16'h0020, 16'h1235));
    send("b2", mk_rec(16'h1000, 16'h0020, 16'h1234), 11'h000, 1'b0, 16'h0, 16'h0);
    check("b2_mis",    32'(mis_valid), 32'd0);
    check("b2_fields", 32'(mis_fields), 32'h000);
    check("b2_err",    32'(err_cnt), 32'd1);
    push(mk_rec(16'h1000, 16'h0022, 16'h1235));
    send("b3", mk_rec(16'h1000, 16'h0024, 16'h1235), 11'h000, 1'b0, 16'h0, 16'h0);
    check("b3_mis",    32'(mis_valid), 32'd1);
    check("b3_fields", 32'(mis_fields), 32'h002);
    check("b3_err",    32'(err_cnt), 32'd2);
    check("b3_halt",   32'(halted), 32'd1);

    // C: jump to F000:0100, two stale records dropped
    pulse_clr();
    check("c_halt0", 32'(halted), 32'd0);
    check("c_err0",  32'(err_cnt), 32'd0);
    push(mk_rec(16'hF000, 16'h0003, 16'h0000));
    push(mk_rec(16'hF000, 16'h0005, 16'h0000));
    push(mk_rec(16'hF000, 16'h0007, 16'h0000));
    push(mk_rec(16'hF000, 16'h0100, 16'h0000));
    send("c_jmp", mk_rec(16'hF000, 16'h0003, 16'h0000), 11'h7FF, 1'b1, 16'hF000, 16'h0100);
    check("c_jmp_mis", 32'(mis_valid), 32'd0);
    check("c_rs_ready", 32'(ref_ready), 32'd0);
    cyc = 0;
    while (!ref_ready && cyc < 20) begin
      step();
      cyc++;
    end
    check("c_rs_cycles", 32'(cyc), 32'd3);
    check("c_drop", 32'(drop_cnt), STATS ? 32'd2 : 32'd0);
    send("c_tgt", mk_rec(16'hF000, 16'h0100, 16'h0000), 11'h7FF, 1'b0, 16'h0, 16'h0);
    check("c_tgt_mis", 32'(mis_valid), 32'd0);
    check("c_err",     32'(err_cnt), 32'd0);
    check("c_cmp",     cmp_cnt, STATS ? 32'd2 : 32'd0);
    check("c_empty",   32'(ref_ready), 32'd0);

    // D: halt after ERR_MAX=2 mismatches, third record left queued
    pulse_clr();
    for (int i = 0; i < 3; i++) push(mk_rec(16'h2000, 16'(48 + i), 16'h5555));
    send("d0", mk_rec(16'h2000, 16'd48, 16'h5556), 11'h7FF, 1'b0, 16'h0, 16'h0);
    check("d0_err",  32'(err_cnt), 32'd1);
    check("d0_halt", 32'(halted), 32'd0);
    send("d1", mk_rec(16'h2000, 16'd49, 16'h5556), 11'h7FF, 1'b0, 16'h0, 16'h0);
    check("d1_err",   32'(err_cnt), 32'd2);
    check("d1_halt",  32'(halted), 32'd1);
    check("d1_ready", 32'(ref_ready), 32'd0);
    repeat (3) step();
    check("d_hold_halt",  32'(halted), 32'd1);
    check("d_hold_ready", 32'(ref_ready), 32'd0);
    check("d_hold_err",   32'(err_cnt), 32'd2);
    dut_valid = 1'b1;
    dut_regs  = mk_rec(16'h2000, 16'd60, 16'h5555);
    clr       = 1'b1;
    step();
    clr       = 1'b0;
    dut_valid = 1'b0;
    check("d_clr_halt",  32'(halted), 32'd0);
    check("d_clr_err",   32'(err_cnt), 32'd0);
    check("d_clr_ready", 32'(ref_ready), 32'd0);
    check("d_clr_cmp",   cmp_cnt, 32'd0);

    // E: overflow on 9th push, then full push with simultaneous pop
    pulse_clr();
    for (int i = 0; i < 8; i++) push(mk_rec(16'h3000, 16'(i), 16'h7000));
    check("e_ovf0", 32'(overflow), 32'd0);
    push(mk_rec(16'h3000, 16'd8, 16'h7000));
    check("e_ovf1", 32'(overflow), 32'd1);
    drain("e", 0, 8);
    check("e_ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check("e2_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) push(mk_rec(16'h3000, 16'(i), 16'h7000));
    dut_valid = 1'b1;
    dut_regs  = mk_rec(16'h3000, 16'd8, 16'h7000);
    send("e2_pp", mk_rec(16'h3000, 16'd0, 16'h7000), 11'h7FF, 1'b0, 16'h0, 16'h0);
    dut_valid = 1'b0;
    check("e2_mis", 32'(mis_valid), 32'd0);
    check("e2_ovf", 32'(overflow), 32'd0);
    drain("e2", 1, 8);

    // F: asynchronous reset in the middle of a resync
    pulse_clr();
    push(mk_rec(16'h4000, 16'h0003, 16'h0000));
    push(mk_rec(16'h4000, 16'h0005, 16'h0000));
    push(mk_rec(16'h4000, 16'h0007, 16'h0000));
    send("f_jmp", mk_rec(16'h4000, 16'h0003, 16'h0001), 11'h7FF, 1'b1, 16'h4000, 16'h0100);
    check("f_mis", 32'(mis_valid), 32'd1);
    check("f_err", 32'(err_cnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("f_ar_ready",  32'(ref_ready), 32'd0);
    check("f_ar_mis",    32'(mis_valid), 32'd0);
    check("f_ar_fields", 32'(mis_fields), 32'd0);
    check("f_ar_err",    32'(err_cnt), 32'd0);
    check("f_ar_halt",   32'(halted), 32'd0);
    check("f_ar_drop",   32'(drop_cnt), 32'd0);
    #2 reset = 1'b0;
    step();
    check("f_post_empty", 32'(ref_ready), 32'd0);
    push(mk_rec(16'h4000, 16'h0005, 16'h0000));
    send("f_post", mk_rec(16'h4000, 16'h0005, 16'h0000), 11'h7FF, 1'b0, 16'h0, 16'h0);
    check("f_post_mis", 32'(mis_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
